mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin select generator for the 4-input multiplexer stage; sits directly upstream and drives its S1/S0 select lines. Arbitrates four request lines (channel 0..3 = mux inputs A..D) and holds each grant for a bounded number of cycles. Provides a one-hot grant for the sources and a VALID qualifier for the mux output consumer.

Parameters:
HOLD_CYCLES, 4, max consecutive cycles one grant stays active; legal range 1..(2**CNT_W)
CNT_W, 3, width of hold counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, synchronous, active-high
EN  input  1  arbitration enable
REQ  input  4  request per channel; bit0=A, bit1=B, bit2=C, bit3=D
S0  output  1  mux select LSB, registered
S1  output  1  mux select MSB, registered; {S1,S0} = granted channel index
GNT  output  4  one-hot grant, registered; all-zero when no grant
VALID  output  1  high while a grant is active; mux output Y is meaningful only when VALID=1
SWITCH  output  1  one-cycle pulse on the first cycle of a grant whose index differs from the previous grant

Behaviour:
- Reset (RST=1 at edge): S0=0, S1=0, GNT=4'b0000, VALID=0, SWITCH=0, state=IDLE, last-grant pointer=3 (so channel 0 has top priority first), counter=0. RST has priority over every other input.
- States: IDLE, GRANT.
- IDLE: if EN=1 and REQ!=0, pick first set REQ bit searching from (pointer+1) mod 4 upward with wrap. Next edge: GRANT, GNT=one-hot of pick, {S1,S0}=pick, VALID=1, counter=HOLD_CYCLES-1, pointer=pick. Latency REQ -> GNT/VALID = 1 cycle.
- IDLE with EN=0 or REQ=0: stay IDLE; S1/S0 hold last value; GNT=0, VALID=0.
- GRANT, release condition = (counter==0) OR (REQ[granted]==0) OR (EN==0).
- GRANT, no release: counter decrements by 1; outputs unchanged.
- GRANT, release with EN=1 and another request: re-arbitrate in the same cycle, search from (granted+1) mod 4 with wrap; current channel is re-granted only if it is the sole requester. Back-to-back handoff, no bubble: VALID stays 1, new GNT/S1/S0/counter loaded at next edge.
- GRANT, release with EN=0 or REQ==0: next edge -> IDLE, GNT=0, VALID=0; S1/S0 hold.
- SWITCH=1 for exactly the first cycle of a grant whose index != previous grant index (including first grant after reset if index != 3); else 0. Re-grant of same channel: SWITCH=0.
- HOLD_CYCLES=1: every grant lasts exactly one cycle; continuous requests rotate every cycle.
- GNT always one-hot or zero; GNT!=0 iff VALID=1; {S1,S0} == index of set GNT bit whenever VALID=1.
- REQ deasserting mid-grant: grant ends at next edge (one cycle of VALID with dropped request is allowed and expected).

Optional Feature:
MUX4_RR_LOCK_EN
- Defined: adds input LOCK (1 bit). While in GRANT and LOCK=1, counter is frozen and expiry (counter==0) does not release; REQ drop or EN=0 still release. Used for multi-beat transfers that must not be split.
- Not defined: no LOCK port; behaviour exactly as above.

Test Plan:
- Reset: assert RST 2 cycles with REQ=4'b1111, EN=1 -> S1S0=00, GNT=0000, VALID=0, SWITCH=0 during reset; first edge after release -> GNT=0001, S1S0=00, VALID=1, SWITCH=1.
- Rotation: EN=1, REQ=4'b1111 held, HOLD_CYCLES=4 -> GNT sequence 0001,0010,0100,1000,0001 each 4 cycles, VALID constant 1, SWITCH pulse every 4th cycle.
- Sparse + wrap: REQ=4'b1001 -> grant ch0 (S1S0=00) then ch3 (S1S0=11) then ch0; ch1/ch2 never granted.
- Early drop: granted ch2 with REQ=4'b0100, drop REQ[2] at cycle 1 of grant -> next edge GNT=0000, VALID=0, S1S0 stays 10.
- Sole requester: REQ=4'b0010 constant -> ch1 re-granted back-to-back every HOLD_CYCLES, VALID never drops, SWITCH=0 after first grant.
- Mid-operation reset/EN: RST=1 during ch2 grant -> next edge all outputs at reset values, pointer=3; separately EN=0 during grant -> next edge IDLE, VALID=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin select generator for a 4:1 mux (optional LOCK via MUX4_RR_LOCK_EN)
module mux4_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] REQ,
`ifdef MUX4_RR_LOCK_EN
  input  logic       LOCK,
`endif
  output logic       S0,
  output logic       S1,
  output logic [3:0] GNT,
  output logic       VALID,
  output logic       SWITCH
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;     // index of the most recent grant
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic             r_valid;
  logic             r_switch;

  logic [1:0]       w_pick;
  logic             w_arb;
  logic             w_lock;
  logic             w_release;

`ifdef MUX4_RR_LOCK_EN
  assign w_lock = LOCK;
`else
  assign w_lock = 1'b0;
`endif

  assign w_arb = EN && (REQ != 4'b0000);

  // A locked grant ignores expiry; losing the request or enable still ends it.
  assign w_release = ((r_cnt == '0) && !w_lock) || !REQ[r_ptr] || !EN;

  // Search from the channel after the last grant, wrapping; the last channel comes up last.
  always_comb begin
    w_pick = r_ptr;
    for (int i = 4; i >= 1; i--) begin
      if (REQ[r_ptr + 2'(i)]) w_pick = r_ptr + 2'(i);
    end
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd3;
      r_sel    <= 2'd0;
      r_cnt    <= '0;
      r_gnt    <= 4'b0000;
      r_valid  <= 1'b0;
      r_switch <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb) begin
            r_state  <= ST_GRANT;
            r_gnt    <= 4'b0001 << w_pick;
            r_sel    <= w_pick;
            r_valid  <= 1'b1;
            r_cnt    <= HOLD_M1;
            r_ptr    <= w_pick;
            r_switch <= (w_pick != r_ptr);
          end else begin
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_release) begin
            if (!w_lock) r_cnt <= r_cnt - 1'b1;
          end else if (w_arb) begin
            r_gnt    <= 4'b0001 << w_pick;
            r_sel    <= w_pick;
            r_valid  <= 1'b1;
            r_cnt    <= HOLD_M1;
            r_ptr    <= w_pick;
            r_switch <= (w_pick != r_ptr);
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign S0     = r_sel[0];
  assign S1     = r_sel[1];
  assign GNT    = r_gnt;
  assign VALID  = r_valid;
  assign SWITCH = r_switch;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       sw;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       lock;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       valid;
  logic       sw;

  int n_cmp;
  int n_bad;

  vec_t vecs[$];
  vec_t sb[$];

  mux4_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .CLK    (clk),
    .RST    (rst),
    .EN     (en),
    .REQ    (req),
`ifdef MUX4_RR_LOCK_EN
    .LOCK   (lock),
`endif
    .S0     (s0),
    .S1     (s1),
    .GNT    (gnt),
    .VALID  (valid),
    .SWITCH (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [3:0] q,
                     input logic [3:0] g, input logic [1:0] s, input logic v, input logic w,
                     input int times);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.gnt = g; t.sel = s; t.valid = v; t.sw = w;
    for (int k = 0; k < times; k++) vecs.push_back(t);
  endtask

  task automatic apply(input vec_t v, input int row);
    vec_t e;
    rst = v.rst; en = v.en; req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt",    row, gnt,                  e.gnt);
    chk("sel",    row, {2'b00, s1, s0},      {2'b00, e.sel});
    chk("valid",  row, {3'b000, valid},      {3'b000, e.valid});
    chk("switch", row, {3'b000, sw},         {3'b000, e.sw});
  endtask

  initial begin
    logic       p_en;
    logic [3:0] p_req;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; en = 1'b0; req = 4'b0000; lock = 1'b0;

    // reset held two cycles with everything requesting
    add(1, 1, 4'hF, 4'b0000, 2'd0, 0, 0, 2);
    // rotation, each grant lasts four cycles
    add(0, 1, 4'hF, 4'b0001, 2'd0, 1, 1, 1);
    add(0, 1, 4'hF, 4'b0001, 2'd0, 1, 0, 3);
    for (int ch = 1; ch < 4; ch++) begin
      add(0, 1, 4'hF, 4'(1 << ch), 2'(ch), 1, 1, 1);
      add(0, 1, 4'hF, 4'(1 << ch), 2'(ch), 1, 0, 3);
    end
    add(0, 1, 4'hF, 4'b0001, 2'd0, 1, 1, 1);
    // sparse requests with wrap: ch0 -> ch3 -> ch0
    add(0, 1, 4'h9, 4'b0001, 2'd0, 1, 0, 3);
    add(0, 1, 4'h9, 4'b1000, 2'd3, 1, 1, 1);
    add(0, 1, 4'h9, 4'b1000, 2'd3, 1, 0, 3);
    add(0, 1, 4'h9, 4'b0001, 2'd0, 1, 1, 1);
    add(0, 1, 4'h9, 4'b0001, 2'd0, 1, 0, 3);
    // ch2 granted, request dropped in its first cycle
    add(0, 1, 4'h4, 4'b0100, 2'd2, 1, 1, 1);
    add(0, 1, 4'h0, 4'b0000, 2'd2, 0, 0, 2);
    // sole requester re-granted without a bubble
    add(0, 1, 4'h2, 4'b0010, 2'd1, 1, 1, 1);
    add(0, 1, 4'h2, 4'b0010, 2'd1, 1, 0, 8);
    // request drop with another requester: handoff, then EN=0 mid-grant
    add(0, 1, 4'h4, 4'b0100, 2'd2, 1, 1, 1);
    add(0, 0, 4'h4, 4'b0000, 2'd2, 0, 0, 2);
    add(0, 1, 4'h4, 4'b0100, 2'd2, 1, 0, 1);
    // reset mid-grant restores pointer to 3
    add(1, 1, 4'h4, 4'b0000, 2'd0, 0, 0, 1);
    add(0, 1, 4'h4, 4'b0100, 2'd2, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // random traffic: structural grant invariants
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      en  = ($urandom_range(0, 5) != 0);
      req = 4'($urandom_range(0, 15));
      p_en = en; p_req = req;
      @(posedge clk); #1;
      chk("valid_iff_gnt", 1000 + c, {3'b000, valid}, {3'b000, (gnt != 4'b0000)});
      chk("gnt_onehot0",   1000 + c, {3'b000, $onehot0(gnt)}, 4'b0001);
      if (valid) begin
        chk("gnt_matches_sel", 1000 + c, gnt, 4'(1 << {s1, s0}));
        chk("gnt_was_requested", 1000 + c, {3'b000, p_req[{s1, s0}] & p_en}, 4'b0001);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
